// File: rtl/eth_loopback_buf_if.sv
// Valid/ready framed-stream bundle for the loopback buffer: ingress and egress
// channels with their last sideband, seen from the source (master) or the buffer (slave).
interface eth_loopback_buf_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              last_in;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic              last_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output data_in, last_in, valid_in, ready_in,
    input  ready_out, data_out, last_out, valid_out
  );

  modport slave (
    input  data_in, last_in, valid_in, ready_in,
    output ready_out, data_out, last_out, valid_out
  );
endinterface

// File: rtl/eth_loopback_buf.sv
// Ethernet loopback FIFO: buffers framed words and returns them either cut-through
// (MODE=0) or store-and-forward (MODE=1) with forced release of oversize packets.
module eth_loopback_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  eth_loopback_buf_if.slave   bus,
  output logic [15:0]         pkt_count,
  output logic [7:0]          oversize_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     pkts_stored;
  logic [AW:0]     pkts_next;
  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [DATA_W:0] head_word;
  logic            empty;
  logic            full;
  logic            vld_int;
  logic            push;
  logic            pop;
  logic            push_last;
  logic            pop_last;
  logic            force_enter;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_word = mem[rd_ptr[AW-1:0]];

  // Outputs are forced quiet while reset is held, regardless of stale RAM contents.
  assign bus.ready_out = rst && !full;
  assign bus.valid_out = rst && vld_int;
  assign bus.data_out  = rst ? head_word[DATA_W-1:0] : '0;
  assign bus.last_out  = rst && head_word[DATA_W];

  assign push      = bus.valid_in && bus.ready_out;
  assign pop       = bus.valid_out && bus.ready_in;
  assign push_last = push && bus.last_in;
  assign pop_last  = pop && head_word[DATA_W];
  assign pkts_next = pkts_stored + (AW+1)'(push_last) - (AW+1)'(pop_last);

  assign force_enter = (MODE != 0) && (state == ST_WAIT) && (pkts_stored == '0) && full;

  always_comb begin
    vld_int = !empty;
    if (MODE != 0) begin
      vld_int = (state != ST_WAIT) && !empty;
    end
  end

  always_comb begin
    state_next = state;
    if (MODE != 0) begin
      case (state)
        ST_WAIT: begin
          if (pkts_stored != '0) begin
            state_next = ST_SEND;
          end else if (full) begin
            state_next = ST_FORCE;
          end
        end
        ST_SEND: begin
          if (pop_last && (pkts_next == '0)) begin
            state_next = ST_WAIT;
          end
        end
        ST_FORCE: begin
          // The oversize packet ends here; resume normal release if whole packets queued behind it.
          if (pop_last) begin
            state_next = (pkts_next != '0) ? ST_SEND : ST_WAIT;
          end
        end
        default: state_next = ST_WAIT;
      endcase
    end else begin
      state_next = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pkts_stored    <= '0;
      state          <= ST_WAIT;
      pkt_count      <= '0;
      oversize_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      pkts_stored <= pkts_next;
      state       <= state_next;
      if (pop_last) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (force_enter && (oversize_count != 8'hFF)) begin
        oversize_count <= oversize_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.last_in, bus.data_in};
    end
  end

endmodule

// File: doc/eth_loopback_buf.md
# eth_loopback_buf

Parametrised successor to the single-byte Ethernet loopback datapath. It accepts a framed stream on the ingress valid/ready channel, buffers it in a DEPTH-word FIFO and returns it on the egress valid/ready channel. The data width is configurable. Frame boundaries are carried on `last` sideband signals. The block runs in one of two modes: cut-through (MODE=0) or store-and-forward (MODE=1). It sits between the MAC-side bus functional model (BFM) and the loopback DUT wrapper, and replaces the unbuffered 8-bit path.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1).
- DEPTH, 16, FIFO depth in words; power of two, ≥4.
- MODE, 0, 0 = cut-through, 1 = store-and-forward.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- data_in  input  DATA_W  ingress data.
- last_in  input  1  ingress final word of packet.
- valid_in  input  1  ingress word valid.
- ready_out  output  1  block can accept an ingress word.
- data_out  output  DATA_W  egress data.
- last_out  output  1  egress final word of packet.
- valid_out  output  1  egress word valid.
- ready_in  input  1  sink accepts the egress word.
- pkt_count  output  16  packets fully sent (egress handshake with last_out = 1); wraps modulo 2^16.
- oversize_count  output  8  store-and-forward forced releases; saturates at 255.

## Operation
- **Ingress push:** occurs when valid_in && ready_out. {last_in, data_in} is written at the write pointer.
- **Egress pop:** occurs when valid_out && ready_in.
- **Pointers:** wr_ptr and rd_ptr are clog2(DEPTH)+1 bits wide.
  - Empty: pointers are equal.
  - Full: address bits are equal and the MSBs differ.
  - Both wrap naturally.
- **ready_out:** equals !full while rst is high. A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- **data_out / last_out:** always reflect the entry at rd_ptr (show-ahead). They are don't-care when valid_out = 0.
- **pkts_stored:** clog2(DEPTH)+1 bits. Increments on a push with last_in = 1. Decrements on a pop with last_out = 1. Both in one cycle leaves it unchanged.
- **MODE=0:** valid_out = !empty. The FSM is held in WAIT and oversize_count stays 0.
- **MODE=1 FSM** (states WAIT, SEND, FORCE; state is registered, valid_out is decoded combinationally from it):
  - WAIT: valid_out = 0.
    - → SEND when pkts_stored > 0.
    - → FORCE when full && pkts_stored == 0; oversize_count increments on this transition.
  - SEND: valid_out = !empty.
    - → WAIT when a last_out pop leaves pkts_stored == 0 (next value).
    - Otherwise stay in SEND.
  - FORCE: valid_out = !empty, covering an oversize packet that streams through.
    - On a pop with last_out = 1: → SEND if next pkts_stored > 0, else → WAIT.
- **Malformed input:** a packet with no last_in is never treated as complete. In MODE=1 it can only leave through FORCE.

## Timing
- **Reset** (rst low at a rising edge):
  - Pointers, pkts_stored, pkt_count and oversize_count are cleared to 0; FSM goes to WAIT.
  - While rst is low: ready_out = 0, valid_out = 0, last_out = 0, data_out = 0.
  - FIFO RAM contents are not reset.
  - Reset asserted mid-packet discards all buffered words. The first ingress word accepted after reset is treated as a packet start.
- **MODE=0 latency:** a word pushed at edge N drives valid_out high in the cycle after edge N (1 cycle), provided the FIFO was empty.
- **MODE=1 latency:** valid_out rises in the second cycle after the edge that pushes last_in (WAIT→SEND registered at that edge + 1). The packet then streams at one word per cycle while ready_in is high.
- **ready_out after full:** rises the cycle after the first pop from a full FIFO.
- **Backpressure:** with ready_in = 0, data_out and last_out hold stable while valid_out = 1.
- **Counter updates:** pkt_count updates at the edge of the last_out handshake and is visible the next cycle.

## Test plan
- **Cut-through single packet:** MODE=0, DATA_W=8, DEPTH=16. After reset, push 0x11,0x22,0x33 (last on 0x33) with ready_in = 1 → the same bytes appear 1 cycle later, last_out on 0x33, pkt_count = 1.
- **Store-and-forward hold:** MODE=1. Push a 5-word packet 0xA0–0xA4 with ready_in = 1 → valid_out stays 0 until 2 cycles after 0xA4 is pushed, then 5 consecutive words; pkt_count = 1.
- **Full/backpressure:** DEPTH=4, ready_in = 0. Push 4 words → ready_out = 0 after the 4th push and the 5th word is not accepted. Set ready_in = 1 → ready_out returns 1 one cycle after the first pop; all words are delivered in order.
- **Oversize release:** MODE=1, DEPTH=4, ready_in = 0. Push a 6-word packet → FSM enters FORCE when full, oversize_count = 1. Release ready_in → all 6 words exit in order, last_out on the 6th, FSM returns to WAIT.
- **Simultaneous push/pop at wrap:** DEPTH=4. Stream 20 words continuously with ready_in = 1 → occupancy stays constant and data order is intact across pointer wrap.
- **Mid-packet reset:** push 3 words without last, then hold rst low for 1 cycle → ready_out and valid_out are 0 during reset. A following 2-word packet is returned alone and pkt_count = 1.
